// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// byte-enable patterns and small decode helpers.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LBU);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_LH) || (f3 == F3_LHU);
  endfunction

  // Anything that is not a byte or half access is handled as a word.
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    if (is_byte(f3))      return BE_BYTE << off;
    else if (is_half(f3)) return BE_HALF << off;
    else                  return BE_WORD;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    if (is_byte(f3))      return {4{d[7:0]}};
    else if (is_half(f3)) return {2{d[15:0]}};
    else                  return d;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the byte/half lane of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane selection and extension by access size/sign.
  always_comb begin
    case (offset)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   value = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  value = {24'b0, lane_b};
      F3_LH:   value = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  value = {16'b0, lane_h};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: drives a req/ack data bus, stalls the core while an access
// is outstanding and returns formatted load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [2:0]     f3_q;
  logic [1:0]     off_q;
  logic [31:0]    load_val;
  logic           start, ack_hit, timeout;

  assign misaligned = mem_req &
                      ((is_half(funct3) & addr[0]) |
                       (!is_byte(funct3) & !is_half(funct3) & (addr[1:0] != 2'b00)));

  assign stall = mem_req & !misaligned & (state != DONE);

  mem_load_align u_align (
    .word   (bus_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .value  (load_val)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; ack takes priority over the timeout.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    ack_hit    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && !misaligned) begin
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          ack_hit    = 1'b1;
          state_next = DONE;
        end else if (cnt == CW'(WAIT_LIMIT)) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus request/attribute latches, wait counter, load data and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      cnt       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_we;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= byte_enable(funct3, addr[1:0]);
        bus_wdata <= lane_data(funct3, wdata);
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        cnt       <= '0;
      end
      if (ack_hit) begin
        bus_req <= 1'b0;
        if (!bus_we) rdata <= load_val;
      end
      if (timeout) begin
        bus_req <= 1'b0;
        err     <= 1'b1;
        if (!bus_we) rdata <= '0;
      end
      if (state == BUSY && !ack_hit && !timeout) cnt <= cnt + CW'(1);
    end
  end

endmodule
